dispensador_troco: RTL and testbench
====================================

DISPENSADOR_TROCO -- requirements
Module: dispensador_troco

Interface
REQ-001 SHALL have: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: pedido_valid  input  1  change request strobe.
REQ-004 SHALL have: pedido_ready  output  1  high only in IDLE; request accepted when pedido_valid && pedido_ready.
REQ-005 SHALL have: valor_troco  input  8  change amount in cents, sampled on acceptance.
REQ-006 SHALL have: carregar  input  1  add moedas_carga to inventory this cycle.
REQ-007 SHALL have: moedas_carga  input  24  coin counts to add; [7:0]=R$0,25, [15:8]=R$0,50, [23:16]=R$1,00.
REQ-008 SHALL have: moedas_estoque  output  24  current inventory, same field layout.
REQ-009 SHALL have: moeda_valid  output  1  a coin is presented to the ejector.
REQ-010 SHALL have: moeda_tipo  output  2  0=25, 1=50, 2=100 cents; 3 unused.
REQ-011 SHALL have: moeda_ack  input  1  ejector took the presented coin.
REQ-012 SHALL have: concluido  output  1  one-cycle end-of-request pulse.
REQ-013 SHALL have: status  output  2  result, valid with concluido: 0 ok, 1 insufficient coins, 2 amount not a multiple of 25, 3 timeout.

Function
REQ-014 SHALL implement states IDLE, PLAN, DISPENSE, DONE; IDLE->PLAN on acceptance; PLAN->DISPENSE if the plan succeeds and amount>0, else PLAN->DONE; DISPENSE->DONE when the plan is exhausted; DONE->IDLE unconditionally.
REQ-015 SHALL, in PLAN (one cycle), compute a greedy plan from the amount and inventory: n100=min(v/100, inv100), then n50=min(rem/50, inv50), then n25=min(rem/25, inv25).
REQ-016 SHALL set status=2 when valor_troco mod 25 != 0 (checked first), status=1 when greedy leaves a remainder; on any PLAN failure, no coin shall be presented and inventory shall be unchanged.
REQ-017 SHALL treat valor_troco=0 as success, with no coins, concluido raised 2 cycles after acceptance.
REQ-018 SHALL dispense 100s first, then 50s, then 25s, with moeda_valid held and moeda_tipo stable until moeda_ack.
REQ-019 SHALL, on a cycle with moeda_valid && moeda_ack, decrement the matching plan count and inventory field by 1; the next coin may be presented the following cycle.
REQ-020 SHALL ignore moeda_ack while moeda_valid is low.
REQ-021 SHALL, on carregar, add each field with saturation at 255, in any state; when a coin ack and carregar hit the same field in one cycle, the net result shall be inventory + carga - 1, saturated.
REQ-022 SHALL ignore pedido_valid outside IDLE; the request is not queued.
REQ-023 SHALL assert concluido and drive status only in DONE; status shall hold its last value otherwise.

Reset
REQ-024 SHALL, on reset asserted at any time (including mid-DISPENSE), go to IDLE and clear inventory, the plan, status, moeda_valid, concluido and moeda_tipo to 0; pedido_ready shall be 1 after reset deasserts.

Configuration
REQ-025 SHALL, with DISPENSADOR_TIMEOUT_EN defined, count cycles while moeda_valid is high without moeda_ack; on reaching 255 cycles, go to DONE with status=3, discard the remaining plan and keep decrements already made.
REQ-026 SHALL, without DISPENSADOR_TIMEOUT_EN, wait for moeda_ack indefinitely; status=3 shall never occur.

Structure
REQ-027 SHALL put the state enum, the moeda_tipo and status encodings, the coin values 25/50/100 and the timeout limit 255 in the shared package dispensador_pkg.
REQ-028 SHALL put the greedy computation in the combinational sub-module planejador_troco (inputs: amount and inventory; outputs: three counts and status).

Verification
REQ-029 SHALL cover: load {100:2, 50:1, 25:3}, request 175 -> coins 100, 50, 25 in order; inventory becomes {1,0,2}; status 0.
REQ-030 SHALL cover: inventory {100:0, 50:1, 25:1}, request 100 -> no moeda_valid, status 1, inventory unchanged.
REQ-031 SHALL cover: request 30 -> status 2 two cycles after acceptance, no coins.
REQ-032 SHALL cover: ack delayed 5 cycles per coin, plus carregar {25:+4} during DISPENSE of a 25 with same-cycle ack -> 25 field = old + 3.
REQ-033 SHALL cover: reset asserted after the first coin ack of a 3-coin plan -> IDLE, moedas_estoque=0, moeda_valid=0 in the same cycle.
REQ-034 SHALL cover, with DISPENSADOR_TIMEOUT_EN: no ack for 255 cycles -> concluido with status 3, moeda_valid low.

Source files
------------

// File: rtl/dispensador_pkg.sv
// dispensador_pkg: shared types and constants for the change dispenser.
//   - estado_e     : controller states (IDLE, PLAN, DISPENSE, DONE)
//   - moeda_tipo_e : coin type code presented on moeda_tipo
//   - status_e     : end-of-request result code
//   - coin values in cents and the ack timeout limit
//   - small helpers: min8, soma_sat (saturating add with optional decrement), maior_moeda
package dispensador_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPlan,
        StDispense,
        StDone
    } estado_e;

    typedef enum logic [1:0] {
        Moeda25  = 2'd0,
        Moeda50  = 2'd1,
        Moeda100 = 2'd2
    } moeda_tipo_e;

    typedef enum logic [1:0] {
        StatusOk      = 2'd0,
        StatusInsuf   = 2'd1,
        StatusMult    = 2'd2,
        StatusTimeout = 2'd3
    } status_e;

    localparam logic [7:0] Valor25       = 8'd25;
    localparam logic [7:0] Valor50       = 8'd50;
    localparam logic [7:0] Valor100      = 8'd100;
    localparam logic [7:0] TimeoutLimite = 8'd255;

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    // a + b - dec, clamped at 255. A decrement only happens on a field that holds at
    // least one coin, so the subtraction never underflows.
    function automatic logic [7:0] soma_sat(input logic [7:0] a, input logic [7:0] b,
                                            input logic dec);
        logic [9:0] s;
        s = {2'b00, a} + {2'b00, b} - {9'd0, dec};
        return (s > 10'd255) ? 8'hFF : s[7:0];
    endfunction

    // Largest coin still pending; callers guarantee at least one count is nonzero.
    function automatic moeda_tipo_e maior_moeda(input logic [7:0] n100, input logic [7:0] n50);
        if (n100 != 8'd0) begin
            return Moeda100;
        end
        if (n50 != 8'd0) begin
            return Moeda50;
        end
        return Moeda25;
    endfunction

endpackage

// File: rtl/planejador_troco.sv
// planejador_troco: combinational greedy change planner.
//   i_valor   : amount in cents
//   i_estoque : inventory, [7:0]=25c, [15:8]=50c, [23:16]=100c
//   o_n100/o_n50/o_n25 : coin counts of the greedy plan
//   o_status  : StatusMult if amount is not a multiple of 25, StatusInsuf if the greedy
//               plan leaves a remainder, StatusOk otherwise
module planejador_troco
    import dispensador_pkg::*;
(
    input  logic [7:0]  i_valor,
    input  logic [23:0] i_estoque,
    output logic [7:0]  o_n100,
    output logic [7:0]  o_n50,
    output logic [7:0]  o_n25,
    output status_e     o_status
);

    logic [7:0] w_rem100;
    logic [7:0] w_rem50;
    logic [7:0] w_rem25;

    always_comb begin
        o_n100   = min8(i_valor / Valor100, i_estoque[23:16]);
        w_rem100 = i_valor - o_n100 * Valor100;
        o_n50    = min8(w_rem100 / Valor50, i_estoque[15:8]);
        w_rem50  = w_rem100 - o_n50 * Valor50;
        o_n25    = min8(w_rem50 / Valor25, i_estoque[7:0]);
        w_rem25  = w_rem50 - o_n25 * Valor25;

        // Multiple-of-25 test takes priority over the inventory shortage.
        if ((i_valor % Valor25) != 8'd0) begin
            o_status = StatusMult;
        end else if (w_rem25 != 8'd0) begin
            o_status = StatusInsuf;
        end else begin
            o_status = StatusOk;
        end
    end

endmodule

// File: rtl/dispensador_troco.sv
// dispensador_troco: coin change dispenser controller.
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   pedido_valid/ready : change request handshake, valor_troco sampled on acceptance
//   carregar           : add moedas_carga to inventory (saturating at 255 per field)
//   moedas_estoque     : current inventory ([7:0]=25c, [15:8]=50c, [23:16]=100c)
//   moeda_valid/tipo   : coin presented to the ejector, held until moeda_ack
//   concluido, status  : one-cycle end-of-request pulse and its result code
// Optional feature: define DISPENSADOR_TIMEOUT_EN to abort a request with StatusTimeout
// after 255 cycles of moeda_valid without moeda_ack.
module dispensador_troco
    import dispensador_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        pedido_valid,
    output logic        pedido_ready,
    input  logic [7:0]  valor_troco,
    input  logic        carregar,
    input  logic [23:0] moedas_carga,
    output logic [23:0] moedas_estoque,
    output logic        moeda_valid,
    output logic [1:0]  moeda_tipo,
    input  logic        moeda_ack,
    output logic        concluido,
    output logic [1:0]  status
);

    estado_e     r_estado;
    logic [7:0]  r_valor;
    logic [23:0] r_estoque;
    logic [7:0]  r_n100;
    logic [7:0]  r_n50;
    logic [7:0]  r_n25;
    logic        r_moeda_valid;
    moeda_tipo_e r_moeda_tipo;
    logic        r_concluido;
    status_e     r_status;
`ifdef DISPENSADOR_TIMEOUT_EN
    logic [7:0]  r_espera;
`endif

    logic [7:0]  w_n100;
    logic [7:0]  w_n50;
    logic [7:0]  w_n25;
    status_e     w_status;
    logic        w_plano_vazio;
    logic        w_ack;
    logic [7:0]  w_prox_n100;
    logic [7:0]  w_prox_n50;
    logic [7:0]  w_prox_n25;
    logic        w_prox_vazio;
    moeda_tipo_e w_prox_tipo;
    logic [23:0] w_carga;

    planejador_troco u_planejador (
        .i_valor   (r_valor),
        .i_estoque (r_estoque),
        .o_n100    (w_n100),
        .o_n50     (w_n50),
        .o_n25     (w_n25),
        .o_status  (w_status)
    );

    assign w_plano_vazio = (w_n100 == 8'd0) && (w_n50 == 8'd0) && (w_n25 == 8'd0);
    // moeda_valid is only ever high in DISPENSE, so this also masks acks elsewhere.
    assign w_ack         = r_moeda_valid && moeda_ack;
    assign w_carga       = carregar ? moedas_carga : 24'd0;

    // Plan counts after this cycle's ack, and the coin to present next.
    always_comb begin
        w_prox_n100 = r_n100;
        w_prox_n50  = r_n50;
        w_prox_n25  = r_n25;
        if (w_ack) begin
            case (r_moeda_tipo)
                Moeda100: w_prox_n100 = r_n100 - 8'd1;
                Moeda50:  w_prox_n50  = r_n50 - 8'd1;
                default:  w_prox_n25  = r_n25 - 8'd1;
            endcase
        end
        w_prox_vazio = (w_prox_n100 == 8'd0) && (w_prox_n50 == 8'd0) && (w_prox_n25 == 8'd0);
        w_prox_tipo  = maior_moeda(w_prox_n100, w_prox_n50);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado      <= StIdle;
            r_valor       <= 8'd0;
            r_n100        <= 8'd0;
            r_n50         <= 8'd0;
            r_n25         <= 8'd0;
            r_moeda_valid <= 1'b0;
            r_moeda_tipo  <= Moeda25;
            r_concluido   <= 1'b0;
            r_status      <= StatusOk;
`ifdef DISPENSADOR_TIMEOUT_EN
            r_espera      <= 8'd0;
`endif
        end else begin
            r_concluido <= 1'b0;
            unique case (r_estado)
                StIdle: begin
                    if (pedido_valid) begin
                        r_valor  <= valor_troco;
                        r_estado <= StPlan;
                    end
                end
                StPlan: begin
                    if ((w_status != StatusOk) || w_plano_vazio) begin
                        r_status    <= w_status;
                        r_concluido <= 1'b1;
                        r_estado    <= StDone;
                    end else begin
                        r_n100        <= w_n100;
                        r_n50         <= w_n50;
                        r_n25         <= w_n25;
                        r_moeda_valid <= 1'b1;
                        r_moeda_tipo  <= maior_moeda(w_n100, w_n50);
                        r_estado      <= StDispense;
`ifdef DISPENSADOR_TIMEOUT_EN
                        r_espera      <= 8'd0;
`endif
                    end
                end
                StDispense: begin
                    r_n100 <= w_prox_n100;
                    r_n50  <= w_prox_n50;
                    r_n25  <= w_prox_n25;
                    if (w_ack && w_prox_vazio) begin
                        r_moeda_valid <= 1'b0;
                        r_status      <= StatusOk;
                        r_concluido   <= 1'b1;
                        r_estado      <= StDone;
                    end else begin
                        // Without an ack the counts are unchanged, so the type holds.
                        r_moeda_tipo <= w_prox_tipo;
`ifdef DISPENSADOR_TIMEOUT_EN
                        if (w_ack) begin
                            r_espera <= 8'd0;
                        end else if (r_espera == TimeoutLimite - 8'd1) begin
                            // Abandon the rest of the plan; coins already ejected stay
                            // deducted from inventory.
                            r_n100        <= 8'd0;
                            r_n50         <= 8'd0;
                            r_n25         <= 8'd0;
                            r_moeda_valid <= 1'b0;
                            r_status      <= StatusTimeout;
                            r_concluido   <= 1'b1;
                            r_espera      <= 8'd0;
                            r_estado      <= StDone;
                        end else begin
                            r_espera <= r_espera + 8'd1;
                        end
`endif
                    end
                end
                StDone: begin
                    r_estado <= StIdle;
                end
            endcase
        end
    end

    // Load and ack may hit the same field in one cycle: net effect is +carga-1, saturated.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estoque <= 24'd0;
        end else begin
            r_estoque[7:0]   <= soma_sat(r_estoque[7:0], w_carga[7:0],
                                         w_ack && (r_moeda_tipo == Moeda25));
            r_estoque[15:8]  <= soma_sat(r_estoque[15:8], w_carga[15:8],
                                         w_ack && (r_moeda_tipo == Moeda50));
            r_estoque[23:16] <= soma_sat(r_estoque[23:16], w_carga[23:16],
                                         w_ack && (r_moeda_tipo == Moeda100));
        end
    end

    assign pedido_ready   = (r_estado == StIdle);
    assign moedas_estoque = r_estoque;
    assign moeda_valid    = r_moeda_valid;
    assign moeda_tipo     = r_moeda_tipo;
    assign concluido      = r_concluido;
    assign status         = r_status;

endmodule

// File: tb/tb_dispensador_troco.sv
// tb_dispensador_troco: self-checking bench for dispensador_troco.
// Expected coins and result codes are pushed to queues when a request is issued and
// popped when the DUT presents a coin or raises concluido.
module tb_dispensador_troco;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pedido_valid = 1'b0;
    logic        pedido_ready;
    logic [7:0]  valor_troco = 8'd0;
    logic        carregar = 1'b0;
    logic [23:0] moedas_carga = 24'd0;
    logic [23:0] moedas_estoque;
    logic        moeda_valid;
    logic [1:0]  moeda_tipo;
    logic        moeda_ack = 1'b0;
    logic        concluido;
    logic [1:0]  status;

    int n_erros = 0;
    int n_checks = 0;

    logic [1:0] q_moedas[$];
    logic [1:0] q_status[$];

    dispensador_troco dut (
        .clock          (clock),
        .reset          (reset),
        .pedido_valid   (pedido_valid),
        .pedido_ready   (pedido_ready),
        .valor_troco    (valor_troco),
        .carregar       (carregar),
        .moedas_carga   (moedas_carga),
        .moedas_estoque (moedas_estoque),
        .moeda_valid    (moeda_valid),
        .moeda_tipo     (moeda_tipo),
        .moeda_ack      (moeda_ack),
        .concluido      (concluido),
        .status         (status)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_erros++;
            $display("FAIL %s: obtido=%0d esperado=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic carrega(input logic [7:0] c100, input logic [7:0] c50, input logic [7:0] c25);
        moedas_carga = {c100, c50, c25};
        carregar = 1'b1;
        tick();
        carregar = 1'b0;
        moedas_carga = 24'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Returns at the sample point of the PLAN cycle.
    task automatic aceita(input logic [7:0] v);
        int k;
        k = 0;
        while (!pedido_ready && k < 20) begin
            tick();
            k++;
        end
        check_eq("ready_antes_pedido", pedido_ready, 1);
        valor_troco = v;
        pedido_valid = 1'b1;
        tick();
        pedido_valid = 1'b0;
    endtask

    // Requests that finish without coins: concluido exactly two cycles after acceptance.
    task automatic pedido_direto(input logic [7:0] v, input logic [1:0] st);
        q_status.push_back(st);
        aceita(v);
        check_eq("conc_ciclo1", concluido, 0);
        check_eq("valid_ciclo1", moeda_valid, 0);
        tick();
        check_eq("conc_ciclo2", concluido, 1);
        check_eq("valid_ciclo2", moeda_valid, 0);
        check_eq("sb_status_pend", q_status.size() > 0, 1);
        if (q_status.size() > 0) check_eq("status_direto", status, q_status.pop_front());
        tick();
        check_eq("conc_pulso", concluido, 0);
        check_eq("ready_pos_done", pedido_ready, 1);
        check_eq("status_retido", status, st);
    endtask

    // Acts as the ejector: acks each coin after 'atraso' cycles of moeda_valid. With
    // carga25 set, the first 25c ack coincides with a load of +4 on the 25c field.
    task automatic servir(input int atraso, input bit carga25, output int n_acks);
        int espera;
        bit fim;
        bit carga_feita;
        logic [7:0] antes;
        espera = 0;
        fim = 1'b0;
        carga_feita = 1'b0;
        antes = 8'd0;
        n_acks = 0;
        for (int c = 0; c < 2000 && !fim; c++) begin
            if (concluido) begin
                check_eq("sb_status_pend", q_status.size() > 0, 1);
                if (q_status.size() > 0) check_eq("status", status, q_status.pop_front());
                check_eq("valid_em_done", moeda_valid, 0);
                fim = 1'b1;
            end else begin
                if (moeda_valid) begin
                    check_eq("ready_ocupado", pedido_ready, 0);
                    if (espera < atraso) begin
                        if (q_moedas.size() > 0) check_eq("tipo_estavel", moeda_tipo, q_moedas[0]);
                        espera++;
                    end else begin
                        check_eq("sb_moeda_pend", q_moedas.size() > 0, 1);
                        if (q_moedas.size() > 0) check_eq("moeda_tipo", moeda_tipo, q_moedas.pop_front());
                        if (carga25 && !carga_feita && moeda_tipo == 2'd0) begin
                            antes = moedas_estoque[7:0];
                            moedas_carga = 24'd4;
                            carregar = 1'b1;
                            carga_feita = 1'b1;
                        end
                        moeda_ack = 1'b1;
                        espera = 0;
                        n_acks++;
                    end
                end
                @(posedge clock);
                #1;
                if (moeda_ack && carregar) check_eq("carga_ack_25", moedas_estoque[7:0], antes + 3);
                moeda_ack = 1'b0;
                carregar = 1'b0;
                moedas_carga = 24'd0;
            end
        end
        check_eq("servir_concluiu", fim, 1);
        check_eq("sb_moedas_sobra", q_moedas.size(), 0);
        if (carga25) check_eq("carga25_aplicada", carga_feita, 1);
    endtask

    initial begin
        int n;
        int ciclos;
        int limite;
        bit visto;

        // Reset state
        #1;
        reset = 1'b1;
        #1;
        check_eq("rst_estoque", moedas_estoque, 0);
        check_eq("rst_valid", moeda_valid, 0);
        check_eq("rst_conc", concluido, 0);
        check_eq("rst_status", status, 0);
        check_eq("rst_tipo", moeda_tipo, 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("ready_pos_rst", pedido_ready, 1);

        // Load {100:2, 50:1, 25:3} and request 175 -> 100, 50, 25
        carrega(8'd2, 8'd1, 8'd3);
        check_eq("estoque_carga", moedas_estoque, {8'd2, 8'd1, 8'd3});
        q_moedas.push_back(2'd2);
        q_moedas.push_back(2'd1);
        q_moedas.push_back(2'd0);
        q_status.push_back(2'd0);
        aceita(8'd175);
        servir(0, 1'b0, n);
        check_eq("n_moedas_175", n, 3);
        check_eq("estoque_175", moedas_estoque, {8'd1, 8'd0, 8'd2});

        // Zero amount, then non-multiple of 25
        pedido_direto(8'd0, 2'd0);
        check_eq("estoque_zero", moedas_estoque, {8'd1, 8'd0, 8'd2});
        pedido_direto(8'd30, 2'd2);
        check_eq("estoque_30", moedas_estoque, {8'd1, 8'd0, 8'd2});

        // Insufficient coins: {100:0, 50:1, 25:1}, request 100
        do_reset();
        carrega(8'd0, 8'd1, 8'd1);
        pedido_direto(8'd100, 2'd1);
        check_eq("estoque_insuf", moedas_estoque, {8'd0, 8'd1, 8'd1});

        // Delayed acks with load on the same cycle as a 25c ack
        do_reset();
        carrega(8'd1, 8'd1, 8'd2);
        q_moedas.push_back(2'd2);
        q_moedas.push_back(2'd1);
        q_moedas.push_back(2'd0);
        q_moedas.push_back(2'd0);
        q_status.push_back(2'd0);
        aceita(8'd200);
        servir(5, 1'b1, n);
        check_eq("n_moedas_200", n, 4);
        check_eq("estoque_200", moedas_estoque, {8'd0, 8'd0, 8'd4});

        // Saturation of a load
        carrega(8'd0, 8'd0, 8'd254);
        check_eq("estoque_sat", moedas_estoque, {8'd0, 8'd0, 8'd255});

        // Reset after the first ack of a 3-coin plan
        do_reset();
        carrega(8'd1, 8'd1, 8'd1);
        aceita(8'd175);
        for (int k = 0; k < 10 && !moeda_valid; k++) tick();
        check_eq("rst_mid_valid_ini", moeda_valid, 1);
        check_eq("rst_mid_tipo_ini", moeda_tipo, 2);
        moeda_ack = 1'b1;
        tick();
        moeda_ack = 1'b0;
        check_eq("rst_mid_estoque_ack", moedas_estoque, {8'd0, 8'd1, 8'd1});
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_estoque", moedas_estoque, 0);
        check_eq("rst_mid_valid", moeda_valid, 0);
        check_eq("rst_mid_ready", pedido_ready, 1);
        check_eq("rst_mid_conc", concluido, 0);
        check_eq("rst_mid_tipo", moeda_tipo, 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_mid_ready_pos", pedido_ready, 1);
        check_eq("rst_mid_valid_pos", moeda_valid, 0);

        // Ejector never acks
        do_reset();
        carrega(8'd0, 8'd0, 8'd1);
        aceita(8'd25);
`ifdef DISPENSADOR_TIMEOUT_EN
        limite = 400;
`else
        limite = 300;
`endif
        ciclos = 0;
        visto = 1'b0;
        for (int c = 0; c < limite && !visto; c++) begin
            tick();
            if (concluido) visto = 1'b1;
            else if (moeda_valid) ciclos++;
        end
`ifdef DISPENSADOR_TIMEOUT_EN
        check_eq("timeout_conc", visto, 1);
        check_eq("timeout_ciclos", ciclos, 255);
        check_eq("timeout_status", status, 3);
        check_eq("timeout_valid", moeda_valid, 0);
        check_eq("timeout_estoque", moedas_estoque, {8'd0, 8'd0, 8'd1});
        tick();
        check_eq("timeout_ready", pedido_ready, 1);
`else
        check_eq("sem_timeout_conc", visto, 0);
        check_eq("sem_timeout_ciclos", ciclos, 300);
        check_eq("sem_timeout_valid", moeda_valid, 1);
        q_moedas.push_back(2'd0);
        q_status.push_back(2'd0);
        servir(0, 1'b0, n);
        check_eq("sem_timeout_acks", n, 1);
        check_eq("sem_timeout_estoque", moedas_estoque, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule
